uart_tx_sched: RTL and testbench

//   Shares one uart_tx serializer between NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_sched_if.sv | 27 ++
 rtl/uart_tx_sched.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Requester and uart_tx side signals of the shared-serializer scheduler.
// The scheduler connects through the slave modport; the requesters and the
// uart_tx model connect through the master modport.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 pkt_done;
    logic                 pkt_abort;

    modport master (
        output req, req_data, req_last, tx_busy,
        input  req_ack, grant, tx_start, tx_data, pkt_done, pkt_abort
    );

    modport slave (
        input  req, req_data, req_last, tx_busy,
        output req_ack, grant, tx_start, tx_data, pkt_done, pkt_abort
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one uart_tx serializer between
// NUM_REQ byte-stream requesters. A grant is held from the first byte to the
// byte flagged last; a stalled packet is dropped after TIMEOUT cycles and
// every packet end is followed by GAP_CYCLES of line idle.
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic           sclk,
    input  logic           srst,
    uart_tx_sched_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 last_q, last_d;
    logic                 pkt_done_q, pkt_done_d;
    logic                 pkt_abort_q, pkt_abort_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [GAP_W-1:0]     gap_q, gap_d;

    logic                 sel_req;
    logic                 sel_last;
    logic [7:0]           sel_data;
    logic                 rr_found;
    logic [PTR_W-1:0]     rr_idx;
    logic [PTR_W:0]       rr_sum;
    logic [PTR_W-1:0]     next_ptr;

    assign next_ptr = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;

    // Mux the currently granted requester's lane onto sel_*.
    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == PTR_W'(i)) begin
                sel_req  = bus.req[i];
                sel_last = bus.req_last[i];
                sel_data = bus.req_data[8*i +: 8];
            end
        end
    end

    // Round-robin search starting at ptr_q, wrapping NUM_REQ-1 -> 0.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        rr_sum   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rr_sum = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (rr_sum >= NUM_REQ_W) begin
                rr_sum = rr_sum - NUM_REQ_W;
            end
            if (!rr_found && bus.req[rr_sum[PTR_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[PTR_W-1:0];
            end
        end
    end

    // Next-state and registered-output computation for the packet sequencer.
    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        req_ack_d   = '0;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        last_d      = last_q;
        pkt_done_d  = 1'b0;
        pkt_abort_d = 1'b0;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    gidx_d          = rr_idx;
                    grant_d         = '0;
                    grant_d[rr_idx] = 1'b1;
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (sel_req) begin
                    tx_data_d         = sel_data;
                    tx_start_d        = 1'b1;
                    req_ack_d[gidx_q] = 1'b1;
                    last_d            = sel_last;
                    tmo_d             = '0;
                    state_d           = WAIT_BUSY;
                end else if (tmo_q == TMO_LAST) begin
                    pkt_abort_d = 1'b1;
                    grant_d     = '0;
                    ptr_d       = next_ptr;
                    tmo_d       = '0;
                    gap_d       = '0;
                    state_d     = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (last_q) begin
                        pkt_done_d = 1'b1;
                        grant_d    = '0;
                        ptr_d      = next_ptr;
                        gap_d      = '0;
                        state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any packet in flight silently.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q     <= IDLE;
            gidx_q      <= '0;
            grant_q     <= '0;
            ptr_q       <= '0;
            req_ack_q   <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            last_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_abort_q <= 1'b0;
            tmo_q       <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            req_ack_q   <= req_ack_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            last_q      <= last_d;
            pkt_done_q  <= pkt_done_d;
            pkt_abort_q <= pkt_abort_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
        end
    end

    assign bus.req_ack   = req_ack_q;
    assign bus.grant     = grant_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.pkt_abort = pkt_abort_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: per-lane byte queues feed the requesters, a
// uart_tx model answers tx_start, and expected line events are queued.
module tb_uart_tx_sched;
    localparam int EV_START = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;

    typedef struct {
        int         kind;
        int         lane;
        logic [7:0] data;
    } ev_t;

    logic sclk = 1'b0;
    logic srst = 1'b1;
    bit   hold_all = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   bcnt = 0;

    ev_t        exp_q[$];
    logic [8:0] lane_q[4][$];
    int         req_rise_cyc[4];

    uart_tx_sched_if #(.NUM_REQ(4)) bus ();

    uart_tx_sched #(
        .NUM_REQ   (4),
        .GAP_CYCLES(16),
        .TIMEOUT   (1024)
    ) dut (
        .sclk(sclk),
        .srst(srst),
        .bus (bus)
    );

    initial forever #5 sclk = ~sclk;

    initial forever begin
        @(posedge sclk);
        cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] lane_oh(input int l);
        lane_oh = 4'b0001 << l;
    endfunction

    // uart_tx model: busy rises the cycle after tx_start and stays high 560 cycles.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge sclk);
            if (srst) begin
                bus.tx_busy <= 1'b0;
                bcnt        <= 0;
            end else if (bus.tx_start === 1'b1) begin
                bus.tx_busy <= 1'b1;
                bcnt        <= 560;
            end else if (bcnt == 1) begin
                bus.tx_busy <= 1'b0;
                bcnt        <= 0;
            end else if (bcnt > 1) begin
                bcnt <= bcnt - 1;
            end
        end
    end

    // Requesters: present the head of each lane queue, advance on req_ack.
    initial begin : driver
        logic [8:0] head;
        bus.req      = 4'hF;
        bus.req_data = '0;
        bus.req_last = '0;
        forever begin
            @(negedge sclk);
            if (srst) begin
                for (int i = 0; i < 4; i++) lane_q[i].delete();
                bus.req      = hold_all ? 4'hF : 4'h0;
                bus.req_last = '0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.req_ack[i] === 1'b1 && lane_q[i].size() > 0)
                        void'(lane_q[i].pop_front());
                    if (lane_q[i].size() > 0) begin
                        head = lane_q[i][0];
                        if (bus.req[i] !== 1'b1) req_rise_cyc[i] = cyc;
                        bus.req[i]           = 1'b1;
                        bus.req_data[8*i +: 8] = head[7:0];
                        bus.req_last[i]      = head[8];
                    end else begin
                        bus.req[i]      = 1'b0;
                        bus.req_last[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check_end(input int kind, input string name);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s_unexpected: got %s pulse, expected no event", name, name);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || bus.grant !== 4'b0000) begin
                bad++;
                $display("FAIL %s: got kind=%0d grant=%b, expected kind=%0d grant=0000",
                         name, kind, bus.grant, e.kind);
            end
        end
    endtask

    // Scoreboard monitor: pop and compare whenever the DUT presents an event.
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge sclk);
            if (!srst) begin
                if (bus.tx_start === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL start_unexpected: got data=%h grant=%b, expected no byte",
                                 bus.tx_data, bus.grant);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != EV_START || bus.grant !== lane_oh(e.lane) ||
                            bus.req_ack !== lane_oh(e.lane) || bus.tx_data !== e.data) begin
                            bad++;
                            $display("FAIL start: got grant=%b ack=%b data=%h, expected kind=%0d grant=%b ack=%b data=%h",
                                     bus.grant, bus.req_ack, bus.tx_data, e.kind,
                                     lane_oh(e.lane), lane_oh(e.lane), e.data);
                        end
                    end
                end else if (bus.req_ack !== 4'b0000) begin
                    total++;
                    bad++;
                    $display("FAIL stray_ack: got %b, expected 0000", bus.req_ack);
                end
                if (bus.pkt_done === 1'b1) check_end(EV_DONE, "pkt_done");
                if (bus.pkt_abort === 1'b1) check_end(EV_ABORT, "pkt_abort");
            end
        end
    end

    task automatic push_byte(input int lane, input logic [7:0] d, input logic last);
        lane_q[lane].push_back({last, d});
    endtask

    task automatic expect_ev(input int kind, input int lane, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.lane = lane;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic single(input int lane, input logic [7:0] d);
        expect_ev(EV_START, lane, d);
        expect_ev(EV_DONE, lane, 8'h00);
        push_byte(lane, d, 1'b1);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if (bus.grant !== 4'b0 || bus.req_ack !== 4'b0 || bus.tx_start !== 1'b0 ||
            bus.tx_data !== 8'h00 || bus.pkt_done !== 1'b0 || bus.pkt_abort !== 1'b0) begin
            bad++;
            $display("FAIL %s: got grant=%b ack=%b start=%b data=%h done=%b abort=%b, expected all 0",
                     name, bus.grant, bus.req_ack, bus.tx_start, bus.tx_data,
                     bus.pkt_done, bus.pkt_abort);
        end
    endtask

    // what: 0 tx_start, 1 pkt_done, 2 pkt_abort, 3 grant nonzero, 4 busy high, 5 busy low
    task automatic wait_sig(input int what, input int limit, input string name, output int at);
        bit hit;
        hit = 1'b0;
        at  = -1;
        for (int n = 0; n < limit && !hit; n++) begin
            @(negedge sclk);
            case (what)
                0: hit = (bus.tx_start === 1'b1);
                1: hit = (bus.pkt_done === 1'b1);
                2: hit = (bus.pkt_abort === 1'b1);
                3: hit = ((|bus.grant) === 1'b1);
                4: hit = (bus.tx_busy === 1'b1);
                default: hit = (bus.tx_busy === 1'b0);
            endcase
            if (hit) at = cyc;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: got no event within %0d cycles, expected one", name, limit);
        end
    endtask

    task automatic wait_drain(input int limit, input string name);
        for (int n = 0; n < limit && exp_q.size() != 0; n++) @(negedge sclk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d events outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : main
        int t_start, t_done, t_abort, t_grant, t_fall, t_tmp;

        // 1: reset held with every requester active
        @(posedge sclk);
        for (int i = 0; i < 10; i++) begin
            @(negedge sclk);
            check_idle_outputs("reset_outputs");
            if (i == 8) hold_all = 1'b0;
        end
        srst = 1'b0;

        // 2: two-byte packet on lane 2, latency and inter-packet gap
        expect_ev(EV_START, 2, 8'h55);
        expect_ev(EV_START, 2, 8'hAA);
        expect_ev(EV_DONE, 2, 8'h00);
        push_byte(2, 8'h55, 1'b0);
        push_byte(2, 8'hAA, 1'b1);
        wait_sig(0, 50, "single_first_start", t_start);
        check_int("single_latency", t_start - req_rise_cyc[2], 2);
        wait_sig(1, 3000, "single_done", t_done);
        single(3, 8'h33);
        wait_sig(3, 100, "gap_grant", t_grant);
        check_int("gap_length", t_grant - t_done, 17);
        wait_drain(3000, "single_drain");

        // 3: contention on lanes 0,1,3 then wrap back to lane 0
        single(0, 8'h10);
        single(1, 8'h11);
        single(3, 8'h13);
        wait_drain(5000, "contention_drain");
        single(0, 8'h20);
        single(2, 8'h22);
        wait_drain(4000, "wrap_drain");

        // 4: lane 1 keeps the grant for its whole 3-byte packet
        expect_ev(EV_START, 1, 8'h41);
        expect_ev(EV_START, 1, 8'h42);
        expect_ev(EV_START, 1, 8'h43);
        expect_ev(EV_DONE, 1, 8'h00);
        expect_ev(EV_START, 0, 8'h40);
        expect_ev(EV_DONE, 0, 8'h00);
        push_byte(1, 8'h41, 1'b0);
        push_byte(1, 8'h42, 1'b0);
        push_byte(1, 8'h43, 1'b1);
        wait_sig(0, 100, "lock_byte1", t_tmp);
        wait_sig(0, 1000, "lock_byte2", t_tmp);
        push_byte(0, 8'h40, 1'b1);
        wait_drain(4000, "lock_drain");

        // 5: lane 3 stalls after its first byte and is aborted
        expect_ev(EV_START, 3, 8'h5A);
        expect_ev(EV_ABORT, 3, 8'h00);
        expect_ev(EV_START, 0, 8'h50);
        expect_ev(EV_DONE, 0, 8'h00);
        push_byte(3, 8'h5A, 1'b0);
        wait_sig(0, 100, "stall_byte1", t_tmp);
        wait_sig(4, 10, "stall_busy_rise", t_tmp);
        wait_sig(5, 700, "stall_busy_fall", t_fall);
        push_byte(0, 8'h50, 1'b1);
        wait_sig(2, 1200, "stall_abort", t_abort);
        check_int("abort_timing", t_abort - t_fall, 1025);
        wait_sig(3, 100, "abort_gap_grant", t_grant);
        check_int("abort_gap", t_grant - t_abort, 17);
        wait_drain(1500, "stall_drain");

        // 6: reset while lane 2 waits on its second byte
        expect_ev(EV_START, 2, 8'h61);
        expect_ev(EV_START, 2, 8'h62);
        push_byte(2, 8'h61, 1'b0);
        push_byte(2, 8'h62, 1'b0);
        push_byte(2, 8'h63, 1'b1);
        wait_sig(0, 100, "midrst_byte1", t_tmp);
        wait_sig(0, 1000, "midrst_byte2", t_tmp);
        wait_sig(4, 10, "midrst_busy", t_tmp);
        @(negedge sclk);
        srst = 1'b1;
        @(negedge sclk);
        check_idle_outputs("midrst_outputs");
        check_int("midrst_pending", exp_q.size(), 0);
        @(negedge sclk);
        srst = 1'b0;
        single(0, 8'h70);
        single(3, 8'h73);
        wait_drain(3000, "restart_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
